// File: rtl/ext_mem_multiport_model.sv
// Byte-addressed external memory model with CHANNELS independent master ports.
// Each port has its own latency counter. Reads go through an (RD_LAT-1)-deep
// capture pipeline, and writes commit at the edge that ends the DataRdy cycle.
// A preload port writes single bytes. Sticky flags record conflicting
// requests and requests that fall outside the served range.
module ext_mem_multiport_model #(
    parameter int CHANNELS  = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int BASE_ADDR = 0,
    parameter int MEMSIZE   = 1024,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          oe_ram,
    input  logic [CHANNELS-1:0]          we_ram,
    input  logic [CHANNELS*ADDR_W-1:0]   addr_ram,
    input  logic [CHANNELS*DATA_W-1:0]   Wdata_ram,
    input  logic [CHANNELS*SIZE_W-1:0]   data_ram_size,
    input  logic                         init_we,
    input  logic [ADDR_W-1:0]            init_addr,
    input  logic [7:0]                   init_data,
    output logic [CHANNELS*DATA_W-1:0]   Rdata_ram,
    output logic [CHANNELS-1:0]          DataRdy,
    output logic                         err_conflict,
    output logic                         err_range
);

    localparam int NBYTES  = DATA_W / 8;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int PIPE_D  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam int MEM_AW  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    logic [7:0]        mem_q   [MEMSIZE];
    logic [CNT_W-1:0]  cnt_q   [CHANNELS];
    logic [CNT_W-1:0]  cnt_d   [CHANNELS];
    logic [DATA_W-1:0] pipe_q  [CHANNELS][PIPE_D];
    logic [DATA_W-1:0] rd_now  [CHANNELS];
    logic [DATA_W-1:0] lane_mask [CHANNELS];
    logic [31:0]       offs    [CHANNELS];
    logic [CHANNELS-1:0] in_range, active, conflict, req_bad;
    logic              init_ok;
    logic [31:0]       init_off;
    logic              err_conflict_q, err_range_q;

    assign err_conflict = err_conflict_q;
    assign err_range    = err_range_q;

    // Per-channel decode: span, range check, handshake, read data and counter next state.
    always_comb begin
        int unsigned a, sz, nb, lat, idx;
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        a = 0; sz = 0; nb = 0; lat = 0; idx = 0;
        DataRdy   = '0;
        Rdata_ram = '0;
        in_range  = '0;
        active    = '0;
        conflict  = '0;
        req_bad   = '0;
        init_off  = 32'(init_addr) - BASE_ADDR;
        init_ok   = (32'(init_addr) >= BASE_ADDR) && (32'(init_addr) < BASE_ADDR + MEMSIZE);
        for (int i = 0; i < CHANNELS; i++) begin
            a  = 32'(addr_ram[i*ADDR_W +: ADDR_W]);
            sz = 32'(data_ram_size[i*SIZE_W +: SIZE_W]);
            if (sz > DATA_W) sz = DATA_W;
            nb = (sz + 7) / 8;
            in_range[i] = (a >= BASE_ADDR) && (a + nb <= BASE_ADDR + MEMSIZE);
            offs[i]     = a - BASE_ADDR;
            for (int b = 0; b < DATA_W; b++) lane_mask[i][b] = (b < sz);
            conflict[i] = oe_ram[i] & we_ram[i];
            req_bad[i]  = (oe_ram[i] | we_ram[i]) & ~in_range[i];
            active[i]   = (oe_ram[i] ^ we_ram[i]) & in_range[i];
            lat = oe_ram[i] ? RD_LAT : WR_LAT;
            DataRdy[i]  = !reset && active[i] && (32'(cnt_q[i]) + 1 >= lat);
            cnt_d[i]    = (active[i] && !DataRdy[i]) ? cnt_q[i] + 1'b1 : '0;
            rd_now[i]   = '0;
            for (int k = 0; k < NBYTES; k++) begin
                idx = offs[i] + k;
                if (in_range[i] && idx < MEMSIZE) rd_now[i][k*8 +: 8] = mem_q[MEM_AW'(idx)];
            end
            rd_now[i] = rd_now[i] & lane_mask[i];
            if (DataRdy[i] && oe_ram[i])
                Rdata_ram[i*DATA_W +: DATA_W] = (RD_LAT == 1) ? rd_now[i] : pipe_q[i][PIPE_D-1];
        end
    end

    // Latency counters and read capture pipeline; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                // NOTE: state is updated with <= so every register sees the pre-edge values.
                cnt_q[i] <= '0;
                for (int s = 0; s < PIPE_D; s++) pipe_q[i][s] <= '0;
            end else begin
                cnt_q[i]     <= cnt_d[i];
                pipe_q[i][0] <= rd_now[i];
                for (int s = 1; s < PIPE_D; s++) pipe_q[i][s] <= pipe_q[i][s-1];
            end
        end
    end

    // Memory array: channel commits in index order, then the preload, so later writers win.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; its contents must survive a reset.
        for (int i = 0; i < CHANNELS; i++) begin
            if (DataRdy[i] && we_ram[i]) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (offs[i] + k < MEMSIZE)
                        mem_q[MEM_AW'(offs[i] + k)] <=
                            (mem_q[MEM_AW'(offs[i] + k)] & ~lane_mask[i][k*8 +: 8]) |
                            (Wdata_ram[i*DATA_W + k*8 +: 8] & lane_mask[i][k*8 +: 8]);
                end
            end
        end
        if (init_we && init_ok) mem_q[MEM_AW'(init_off)] <= init_data;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_conflict_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            err_conflict_q <= err_conflict_q | (|conflict);
            err_range_q    <= err_range_q | (|req_bad) | (init_we & ~init_ok);
        end
    end

endmodule
